// File: rtl/csr_exec_unit.sv
// Multi-cycle execute stage for SYSTEM instructions (CSRRW/S/C, immediate forms, ECALL, MRET).
// Sequences IDLE -> READ -> WRITE -> RESP against a single-ported CSR register file.
module csr_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] csr_idx,
  input  logic [4:0]            rs1_idx,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  ecall,
  input  logic                  mret,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] csr_addr_o,
  output logic [DATA_WIDTH-1:0] csr_wdata_o,
  output logic                  csr_wen_o,
  output logic                  csr_ecall_o,
  output logic                  csr_mret_o,
  output logic [DATA_WIDTH-1:0] csr_pc_o,
  input  logic [DATA_WIDTH-1:0] csr_rdata_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e                state_q, state_d;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] csr_q;
  logic [4:0]            rs1_idx_q;
  logic [DATA_WIDTH-1:0] rs1_q, pc_q, old_q, redir_pc_q;
  logic                  ecall_q, mret_q, redir_q;

  logic                  trap, illegal, do_write;
  logic [DATA_WIDTH-1:0] src, wval;

  // mret_q is captured already masked by ecall so ECALL wins when both are set
  assign trap     = ecall_q | mret_q;
  assign illegal  = (f3_q[1:0] == 2'b00);
  assign do_write = !trap && !illegal && ((f3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0));
  assign src      = f3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_q;

  always_comb begin
    case (f3_q[1:0])
      2'b10:   wval = old_q | src;
      2'b11:   wval = old_q & ~src;
      default: wval = src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      csr_q      <= '0;
      rs1_idx_q  <= '0;
      rs1_q      <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      redir_pc_q <= '0;
      ecall_q    <= 1'b0;
      mret_q     <= 1'b0;
      redir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        f3_q      <= funct3;
        csr_q     <= csr_idx;
        rs1_idx_q <= rs1_idx;
        rs1_q     <= rs1_data;
        pc_q      <= pc;
        ecall_q   <= ecall;
        mret_q    <= mret & ~ecall;
      end
      if (state_q == READ) begin
        if (trap) begin
          redir_pc_q <= csr_rdata_i;
          redir_q    <= 1'b1;
          old_q      <= '0;
        end else begin
          redir_q    <= 1'b0;
          old_q      <= csr_rdata_i;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    csr_addr_o     = '0;
    csr_wdata_o    = '0;
    csr_wen_o      = 1'b0;
    csr_ecall_o    = 1'b0;
    csr_mret_o     = 1'b0;
    csr_pc_o       = '0;
    rd_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = READ;
      end
      READ: begin
        csr_addr_o  = csr_q;
        csr_pc_o    = pc_q;
        csr_ecall_o = ecall_q & ~rst;
        csr_mret_o  = mret_q & ~rst;
        state_d     = WRITE;
      end
      WRITE: begin
        csr_addr_o  = csr_q;
        csr_wdata_o = wval;
        csr_wen_o   = do_write & ~rst;
        state_d     = RESP;
      end
      RESP: begin
        out_valid      = 1'b1;
        rd_data        = illegal ? '0 : old_q;
        redirect_valid = redir_q;
        redirect_pc    = redir_q ? redir_pc_q : '0;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: expected writes and responses go into queues,
// independent monitors pop and compare whenever the DUT presents them.
module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [11:0] csr_idx;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic        ecall, mret;
  logic [31:0] pc;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic        csr_wen_o, csr_ecall_o, csr_mret_o;
  logic [31:0] csr_pc_o;
  logic [31:0] csr_rdata_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  csr_exec_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .csr_idx(csr_idx), .rs1_idx(rs1_idx), .rs1_data(rs1_data),
    .ecall(ecall), .mret(mret), .pc(pc),
    .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o), .csr_wen_o(csr_wen_o),
    .csr_ecall_o(csr_ecall_o), .csr_mret_o(csr_mret_o), .csr_pc_o(csr_pc_o),
    .csr_rdata_i(csr_rdata_i), .out_valid(out_valid), .out_ready(out_ready),
    .rd_data(rd_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        rv;
    logic [31:0] rpc;
  } resp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
  } wr_t;

  resp_t       rq[$];
  wr_t         wq[$];
  int          nvec = 0;
  int          nmis = 0;
  int          ecall_cnt = 0;
  int          mret_cnt = 0;
  logic [31:0] exp_trap_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // response monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (rq.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_resp: got rd 0x%08h expected none", rd_data);
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("rd_data", rd_data, e.rd);
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
        if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  // CSR-file side monitor
  always @(negedge clk) begin
    if (csr_wen_o) begin
      if (wq.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_wen: got addr 0x%03h wdata 0x%08h expected none", csr_addr_o, csr_wdata_o);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("csr_addr", {20'd0, csr_addr_o}, {20'd0, w.addr});
        chk("csr_wdata", csr_wdata_o, w.wdata);
      end
    end
    if (csr_ecall_o) begin
      ecall_cnt++;
      chk("ecall_pc", csr_pc_o, exp_trap_pc);
    end
    if (csr_mret_o) begin
      mret_cnt++;
      chk("mret_pc", csr_pc_o, exp_trap_pc);
    end
  end

  // Drive one instruction; expectations are queued before the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] ri,
                       input logic [31:0] rd1, input logic ec, input logic mr,
                       input logic [31:0] ipc, input logic [31:0] rdata,
                       input logic push_resp, input logic [31:0] erd, input logic erv,
                       input logic [31:0] erpc, input logic ewen, input logic [31:0] ewd);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      nvec++; nmis++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    if (push_resp) rq.push_back('{rd: erd, rv: erv, rpc: erpc});
    if (ewen) wq.push_back('{addr: csr, wdata: ewd});
    exp_trap_pc = ipc;
    csr_rdata_i = rdata;
    funct3 = f3; csr_idx = csr; rs1_idx = ri; rs1_data = rd1;
    ecall = ec; mret = mr; pc = ipc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      nvec++; nmis++;
      $display("FAIL drain_timeout: got %0d pending expected 0", rq.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; funct3 = '0; csr_idx = '0; rs1_idx = '0;
    rs1_data = '0; ecall = 1'b0; mret = 1'b0; pc = '0; csr_rdata_i = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_wen", {31'd0, csr_wen_o}, 32'd0);
    chk("reset_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CSRRW with latency check: accept T, out_valid at T+3
    issue(3'b001, 12'h305, 5'd1, 32'h8000_0100, 0, 0, 32'h0, 32'h0,
          1, 32'h0, 0, 32'h0, 1, 32'h8000_0100);
    chk("lat_T1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_T1_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("lat_T2_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_T3_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("lat_T4_in_ready", {31'd0, in_ready}, 32'd1);

    // CSRRS rs1=x0: read only
    issue(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h1800,
          1, 32'h1800, 0, 32'h0, 0, 32'h0);
    // CSRRCI zimm=5 on 0xF -> 0xA
    issue(3'b111, 12'h342, 5'd5, 32'h0, 0, 0, 32'h0, 32'hF,
          1, 32'hF, 0, 32'h0, 1, 32'hA);
    // CSRRS set bits
    issue(3'b010, 12'h340, 5'd3, 32'h0F0, 0, 0, 32'h0, 32'h00F,
          1, 32'h00F, 0, 32'h0, 1, 32'h0FF);
    // CSRRC clear bits
    issue(3'b011, 12'h341, 5'd2, 32'hFF00, 0, 0, 32'h0, 32'hFFFF,
          1, 32'hFFFF, 0, 32'h0, 1, 32'h00FF);
    // CSRRWI uses zimm, ignores rs1_data
    issue(3'b101, 12'h344, 5'h1F, 32'hDEAD, 0, 0, 32'h0, 32'h1234_5678,
          1, 32'h1234_5678, 0, 32'h0, 1, 32'h1F);
    // CSRRSI zimm=0: no write
    issue(3'b110, 12'h304, 5'd0, 32'h0, 0, 0, 32'h0, 32'h888,
          1, 32'h888, 0, 32'h0, 0, 32'h0);
    // illegal funct3 100: no write, rd 0
    issue(3'b100, 12'h305, 5'd7, 32'h55, 0, 0, 32'h0, 32'h1234,
          1, 32'h0, 0, 32'h0, 0, 32'h0);
    // ECALL
    issue(3'b000, 12'h305, 5'd0, 32'h0, 1, 0, 32'h8000_0040, 32'h8000_0200,
          1, 32'h0, 1, 32'h8000_0200, 0, 32'h0);
    drain();
    chk("ecall_pulses", ecall_cnt, 32'd1);

    // MRET with downstream stall
    out_ready = 1'b0;
    issue(3'b000, 12'h341, 5'd0, 32'h0, 0, 1, 32'h8000_0010, 32'h8000_0044,
          1, 32'h0, 1, 32'h8000_0044, 0, 32'h0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_redirect_pc", redirect_pc, 32'h8000_0044);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mret_pulses", mret_cnt, 32'd1);

    // reset during WRITE of CSRRW: nothing written, nothing returned
    issue(3'b001, 12'h305, 5'd1, 32'hCAFE_0000, 0, 0, 32'h0, 32'h0,
          0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_no_resp", {31'd0, out_valid}, 32'd0);
    end

    // ecall+mret both set -> ECALL
    issue(3'b000, 12'h000, 5'd0, 32'h0, 1, 1, 32'h8000_0080, 32'h8000_0300,
          1, 32'h0, 1, 32'h8000_0300, 0, 32'h0);
    drain();
    chk("both_ecall_pulses", ecall_cnt, 32'd2);
    chk("both_mret_pulses", mret_cnt, 32'd1);
    chk("wq_empty", wq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
